// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the hazard unit.
//   FWD_*       : ALU operand mux selects driven on ForwardAE/ForwardBE
//   tmr_state_t : state of the multi-cycle mul/div stall timer
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
   localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM result

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } tmr_state_t;

endpackage

// File: rtl/muldiv_stall_timer.sv
// muldiv_stall_timer: holds F/D/E while a multi-cycle mul/div occupies EX.
//   clk, rst    : pipeline clock, async active-high reset
//   muldiv_E    : EX instruction is a multi-cycle mul/div
//   stall_req   : timer wants StallF/StallD/StallE/FlushM this cycle
//   muldiv_busy : timer is in BUSY
// The op occupies EX for exactly MULDIV_LAT cycles: one IDLE cycle that
// launches the timer, MULDIV_LAT-2 stalled BUSY cycles, and a final BUSY
// "done" cycle in which EX is released.
module muldiv_stall_timer
   import hazard_pkg::*;
#(
   parameter int MULDIV_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic muldiv_E,
   output logic stall_req,
   output logic muldiv_busy
);

   // Wide enough for MULDIV_LAT-2; kept at 1 bit when the count is trivial.
   localparam int CW     = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
   localparam int LOAD_I = (MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0;
   localparam logic [CW-1:0] CNT_LOAD = LOAD_I[CW-1:0];

   tmr_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      stall_req = 1'b0;
      case (state)
         IDLE: begin
            // Single-cycle ops never launch the timer, so cnt stays at 0.
            if (muldiv_E && MULDIV_LAT > 1) begin
               stall_req = 1'b1;
               cnt_n     = CNT_LOAD;
               state_n   = BUSY;
            end
         end
         BUSY: begin
            // muldiv_E is not looked at here: it is the same held instruction.
            if (cnt != '0) begin
               stall_req = 1'b1;
               cnt_n     = cnt - CW'(1);
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // While reset is held the state is IDLE, but a pending muldiv_E must
      // not raise a stall until reset is released.
      if (rst) stall_req = 1'b0;
   end

   assign muldiv_busy = (state == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard unit for the 5-stage RISC-V core with a
// multi-cycle execute path.
//   Inputs : decode/EX/MEM/WB register indices and write enables, load and
//            mul/div flags of the EX instruction, taken-branch PCSrc_E,
//            clr_stats to clear the statistics counter.
//   Outputs: StallF/StallD/StallE, FlushD/FlushE/FlushM pipeline-register
//            controls, ForwardAE/ForwardBE operand selects, muldiv_busy,
//            saturating stall_cycles counter of cycles with StallF=1.
// All control outputs are combinational from inputs and timer state.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_D,
   input  logic [REG_AW-1:0] rs2_D,
   input  logic              use_rs1_D,
   input  logic              use_rs2_D,
   input  logic [REG_AW-1:0] rs1_E,
   input  logic [REG_AW-1:0] rs2_E,
   input  logic [REG_AW-1:0] rd_E,
   input  logic [REG_AW-1:0] rd_M,
   input  logic [REG_AW-1:0] rd_W,
   input  logic              regwrite_M,
   input  logic              regwrite_W,
   input  logic              MemtoregE,
   input  logic              PCSrc_E,
   input  logic              muldiv_E,
   input  logic              clr_stats,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              muldiv_busy,
   output logic [CNT_W-1:0]  stall_cycles
);

   // MEM is the younger producer, so it wins over WB. x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] rdm,
      input logic              wm,
      input logic [REG_AW-1:0] rdw,
      input logic              ww
   );
      if (wm && rdm != '0 && rdm == rs)      return FWD_MEM;
      else if (ww && rdw != '0 && rdw == rs) return FWD_WB;
      else                                   return FWD_RF;
   endfunction

   logic load_use;
   logic tmr_stall;

   muldiv_stall_timer #(
      .MULDIV_LAT (MULDIV_LAT)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .muldiv_E    (muldiv_E),
      .stall_req   (tmr_stall),
      .muldiv_busy (muldiv_busy)
   );

   always_comb begin
      ForwardAE = fwd_sel(rs1_E, rd_M, regwrite_M, rd_W, regwrite_W);
      ForwardBE = fwd_sel(rs2_E, rd_M, regwrite_M, rd_W, regwrite_W);
   end

   assign load_use = MemtoregE && (rd_E != '0) &&
                     ((use_rs1_D && rd_E == rs1_D) || (use_rs2_D && rd_E == rs2_D));

   // A taken branch squashes the decode instruction, so holding it for a
   // load-use is pointless. The timer and load-use never legally overlap;
   // if they do, the timer owns EX and no bubble is injected into ID/EX.
   always_comb begin
      StallF = tmr_stall || (load_use && !PCSrc_E);
      StallD = StallF;
      StallE = tmr_stall;
      FlushM = tmr_stall;
      FlushD = PCSrc_E;
      FlushE = PCSrc_E || (load_use && !tmr_stall);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (clr_stats) begin
         stall_cycles <= '0;
      end else if (StallF && stall_cycles != '1) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

   localparam int AW    = 5;
   localparam int LAT_A = 4;
   localparam int LAT_B = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [AW-1:0] rs1_D = '0, rs2_D = '0, rs1_E = '0, rs2_E = '0;
   logic [AW-1:0] rd_E = '0, rd_M = '0, rd_W = '0;
   logic use_rs1_D = 0, use_rs2_D = 0, regwrite_M = 0, regwrite_W = 0;
   logic MemtoregE = 0, PCSrc_E = 0, muldiv_E = 0, clr_stats = 0;

   logic sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a;
   logic [1:0] fa_a, fb_a;
   logic [15:0] sc_a;
   logic sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b;
   logic [1:0] fa_b, fb_b;
   logic [3:0] sc_b;
   logic [10:0] obs_a, obs_b;

   assign obs_a = {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, fa_a, fb_a, busy_a};
   assign obs_b = {sf_b, sd_b, se_b, fd_b, fe_b, fm_b, fa_b, fb_b, busy_b};

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: cycles of EX occupancy still to come after the
   // current one for the mul/div op, and the two statistics counters.
   int          rem_a = 0;
   logic [15:0] cnt_a = '0;
   logic [3:0]  cnt_b = '0;

   hazard_unit_mc #(.REG_AW(AW), .MULDIV_LAT(LAT_A), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
      .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
      .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .MemtoregE(MemtoregE),
      .PCSrc_E(PCSrc_E), .muldiv_E(muldiv_E), .clr_stats(clr_stats),
      .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .FlushD(fd_a), .FlushE(fe_a),
      .FlushM(fm_a), .ForwardAE(fa_a), .ForwardBE(fb_a), .muldiv_busy(busy_a),
      .stall_cycles(sc_a));

   hazard_unit_mc #(.REG_AW(AW), .MULDIV_LAT(LAT_B), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
      .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
      .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .MemtoregE(MemtoregE),
      .PCSrc_E(PCSrc_E), .muldiv_E(muldiv_E), .clr_stats(clr_stats),
      .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .FlushD(fd_b), .FlushE(fe_b),
      .FlushM(fm_b), .ForwardAE(fa_b), .ForwardBE(fb_b), .muldiv_busy(busy_b),
      .stall_cycles(sc_b));

   always #5 clk = ~clk;

   function automatic logic [1:0] fwd_m(input logic [AW-1:0] rs);
      if (regwrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
      if (regwrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Expected {StallF,StallD,StallE,FlushD,FlushE,FlushM,FwdA,FwdB,busy}.
   function automatic logic [10:0] exp_vec(input int rem, input int lat);
      logic lu, ts, sf;
      lu = MemtoregE && rd_E != 0 &&
           ((use_rs1_D && rd_E == rs1_D) || (use_rs2_D && rd_E == rs2_D));
      ts = !rst && lat > 1 && ((rem == 0 && muldiv_E) || rem > 1);
      sf = ts || (lu && !PCSrc_E);
      return {sf, sf, ts, PCSrc_E, PCSrc_E || (lu && !ts), ts,
              fwd_m(rs1_E), fwd_m(rs2_E), (rem > 0) && !rst};
   endfunction

   task automatic step_model();
      logic [10:0] ea, eb;
      if (rst) begin
         rem_a = 0; cnt_a = '0; cnt_b = '0;
      end else begin
         ea = exp_vec(rem_a, LAT_A);
         eb = exp_vec(0, LAT_B);
         if (clr_stats) cnt_a = '0;
         else if (ea[10] && cnt_a != 16'hFFFF) cnt_a = cnt_a + 16'd1;
         if (clr_stats) cnt_b = '0;
         else if (eb[10] && cnt_b != 4'hF) cnt_b = cnt_b + 4'd1;
         if (rem_a == 0) rem_a = muldiv_E ? LAT_A - 1 : 0;
         else rem_a = rem_a - 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      step_model();
      #1;
   endtask

   task automatic clear_inputs();
      rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
      use_rs1_D = 0; use_rs2_D = 0; regwrite_M = 0; regwrite_W = 0;
      MemtoregE = 0; PCSrc_E = 0; muldiv_E = 0; clr_stats = 0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (obs_a !== 11'b0 || sc_a !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_a: outs %b cnt %0d want 0/0", obs_a, sc_a);
      end
      n_checks++;
      if (obs_b !== 11'b0 || sc_b !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_b: outs %b cnt %0d want 0/0", obs_b, sc_b);
      end
      tick();
      rst = 0;
   endtask

   task automatic test_forwarding();
      logic [1:0] want [3];
      want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b00;
      for (int p = 0; p < 3; p++) begin
         clear_inputs();
         rs1_E = 5; rs2_E = 5; rd_M = 5; rd_W = 5; regwrite_M = 1; regwrite_W = 1;
         if (p == 1) regwrite_M = 0;
         if (p == 2) begin rd_M = 0; rd_W = 0; end
         @(negedge clk);
         n_checks++;
         if (fa_a !== want[p] || fb_a !== want[p]) begin
            n_fail++;
            $display("FAIL fwd_p%0d: A=%b B=%b want %b", p, fa_a, fb_a, want[p]);
         end
         n_checks++;
         if (obs_a !== exp_vec(rem_a, LAT_A)) begin
            n_fail++;
            $display("FAIL fwd_model_p%0d: got %b want %b", p, obs_a, exp_vec(rem_a, LAT_A));
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      clear_inputs();
      MemtoregE = 1; rd_E = 7; rs2_D = 7; use_rs2_D = 1;
      @(negedge clk);
      n_checks++;
      if ({sf_a, sd_a, fe_a, se_a, fd_a} !== 5'b11100) begin
         n_fail++;
         $display("FAIL load_use: SF/SD/FE/SE/FD=%b want 11100", {sf_a, sd_a, fe_a, se_a, fd_a});
      end
      tick();
      use_rs2_D = 0;
      @(negedge clk);
      n_checks++;
      if ({sf_a, sd_a, fe_a} !== 3'b000) begin
         n_fail++;
         $display("FAIL load_use_unused: SF/SD/FE=%b want 000", {sf_a, sd_a, fe_a});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_branch();
      clear_inputs();
      MemtoregE = 1; rd_E = 7; rs2_D = 7; use_rs2_D = 1; PCSrc_E = 1;
      @(negedge clk);
      n_checks++;
      if ({sf_a, sd_a, fd_a, fe_a} !== 4'b0011) begin
         n_fail++;
         $display("FAIL branch: SF/SD/FD/FE=%b want 0011", {sf_a, sd_a, fd_a, fe_a});
      end
      tick();
      clear_inputs();
   endtask

   // Checks one full LAT_A mul/div occupancy starting from IDLE.
   task automatic test_muldiv(input string tag);
      logic [15:0] start;
      start = cnt_a;
      muldiv_E = 1;
      for (int c = 1; c <= LAT_A; c++) begin
         @(negedge clk);
         n_checks++;
         if ({sf_a, sd_a, se_a, fm_a} !== {4{c < LAT_A}} || busy_a !== (c > 1) ||
             fe_a !== 1'b0 || {se_b, busy_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_c%0d: SF/SD/SE/FM=%b busy=%b FE=%b b_SE/busy=%b%b",
                     tag, c, {sf_a, sd_a, se_a, fm_a}, busy_a, fe_a, se_b, busy_b);
         end
         tick();
      end
      muldiv_E = 0;
      @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b0 || se_a !== 1'b0 || sc_a !== start + 16'd3) begin
         n_fail++;
         $display("FAIL %s_end: busy=%b SE=%b cnt=%0d want 0/0/%0d",
                  tag, busy_a, se_a, sc_a, start + 16'd3);
      end
   endtask

   task automatic test_reset_mid_busy();
      clear_inputs();
      muldiv_E = 1;
      tick();                // IDLE launch cycle
      #1 rst = 1;            // second cycle, timer in BUSY
      rem_a = 0; cnt_a = '0; cnt_b = '0;
      #1;
      n_checks++;
      if ({sf_a, sd_a, se_a, fm_a, busy_a} !== 5'b0 || sc_a !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid_busy: stalls/busy=%b cnt=%0d want 0/0",
                  {sf_a, sd_a, se_a, fm_a, busy_a}, sc_a);
      end
      tick();
      rst = 0;
      test_muldiv("muldiv_after_reset");
   endtask

   task automatic test_saturation();
      clear_inputs();
      MemtoregE = 1; rd_E = 7; rs2_D = 7; use_rs2_D = 1;
      repeat (20) tick();
      @(negedge clk);
      n_checks++;
      if (sc_b !== 4'hF || sc_b !== cnt_b) begin
         n_fail++;
         $display("FAIL saturate_b: cnt=%0d want 15", sc_b);
      end
      n_checks++;
      if (sc_a !== cnt_a) begin
         n_fail++;
         $display("FAIL count_a: cnt=%0d want %0d", sc_a, cnt_a);
      end
      clr_stats = 1;
      tick();
      clear_inputs();
      @(negedge clk);
      n_checks++;
      if (sc_a !== 16'd0 || sc_b !== 4'd0) begin
         n_fail++;
         $display("FAIL clr_stats: a=%0d b=%0d want 0/0", sc_a, sc_b);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rs1_D = AW'($urandom_range(0, 3));  rs2_D = AW'($urandom_range(0, 3));
         rs1_E = AW'($urandom_range(0, 3));  rs2_E = AW'($urandom_range(0, 3));
         rd_E  = AW'($urandom_range(0, 3));  rd_M  = AW'($urandom_range(0, 3));
         rd_W  = AW'($urandom_range(0, 3));
         use_rs1_D  = 1'($urandom_range(0, 1)); use_rs2_D  = 1'($urandom_range(0, 1));
         regwrite_M = 1'($urandom_range(0, 1)); regwrite_W = 1'($urandom_range(0, 1));
         MemtoregE  = 1'($urandom_range(0, 1));
         PCSrc_E    = ($urandom_range(0, 5) == 0);
         muldiv_E   = ($urandom_range(0, 7) == 0);
         clr_stats  = ($urandom_range(0, 40) == 0);
         @(negedge clk);
         n_checks++;
         if (obs_a !== exp_vec(rem_a, LAT_A) || sc_a !== cnt_a) begin
            n_fail++;
            $display("FAIL rand_a_%0d: outs %b cnt %0d want %b cnt %0d",
                     i, obs_a, sc_a, exp_vec(rem_a, LAT_A), cnt_a);
         end
         n_checks++;
         if (obs_b !== exp_vec(0, LAT_B) || sc_b !== cnt_b) begin
            n_fail++;
            $display("FAIL rand_b_%0d: outs %b cnt %0d want %b cnt %0d",
                     i, obs_b, sc_b, exp_vec(0, LAT_B), cnt_b);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      clear_inputs();
      test_muldiv("muldiv");
      test_reset_mid_busy();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
